seg_scan_mux: RTL and testbench
===============================

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 Parameter DIV, default 50000: clk cycles each digit is driven per scan slot; legal range 2..2^20.
REQ-002 Parameter GAP, default 500: blanking clk cycles between consecutive digit slots; legal range 1..DIV-1.
REQ-003 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port Seg_Minutes  input  [0:6]  encoded minutes digit; segments active-low.
REQ-006 Port Seg_Tens_Seconds  input  [0:6]  encoded tens-of-seconds digit; segments active-low.
REQ-007 Port Seg_Ones_Seconds  input  [0:6]  encoded ones-of-seconds digit; segments active-low.
REQ-008 Port Seg_Tenths_Seconds  input  [0:6]  encoded tenths digit; segments active-low.
REQ-009 Port Minutes  input  [3:0]  binary minutes value; used only for leading-zero blanking.
REQ-010 Port Blank_Lead  input  1  1 = blank the minutes digit when the captured Minutes is 0.
REQ-011 Port Seg  output  [0:6]  shared segment bus; active-low; 7'b1111111 = dark.
REQ-012 Port An  output  [3:0]  digit enables, active-low; An[3]=minutes, An[2]=tens, An[1]=ones, An[0]=tenths.
REQ-013 Port Dp  output  1  decimal point, active-low.
REQ-014 Port Frame  output  1  one-cycle pulse on the cycle the input snapshot is taken.

Function
REQ-015 The state machine SHALL have two states: ON (a digit is driven) and GAP (all digits dark).
REQ-016 A 2-bit digit index SHALL scan the sequence 3,2,1,0,3,...; it advances by one (mod 4, descending) on the GAP->ON transition.
REQ-017 A cycle counter SHALL count 0..DIV-1 in ON and 0..GAP-1 in GAP; it SHALL be cleared on every state change.
REQ-018 Transition ON->GAP SHALL occur on the cycle the counter equals DIV-1; transition GAP->ON SHALL occur on the cycle the counter equals GAP-1.
REQ-019 In ON, An SHALL have exactly one bit low, at the current index; in GAP, An SHALL be 4'b1111, Seg SHALL be 7'b1111111, and Dp SHALL be 1.
REQ-020 On the GAP->ON transition into index 3, all four Seg_* inputs, Minutes and Blank_Lead SHALL be captured into snapshot registers; Frame SHALL pulse high for that one cycle.
REQ-021 The captured snapshot SHALL drive Seg for the whole frame (indices 3,2,1,0); input changes mid-frame SHALL NOT appear until the next frame.
REQ-022 Seg SHALL be the snapshot segments of the current index, except at index 3 with captured Blank_Lead=1 and captured Minutes=0, where Seg SHALL be 7'b1111111 while An[3] is still driven low.
REQ-023 Dp SHALL be 0 only in ON at index 1 (separating seconds and tenths); otherwise Dp SHALL be 1.
REQ-024 Seg, An and Dp SHALL be registered outputs: the values for a state take effect on the same edge that enters that state, with no combinational path from inputs to outputs.
REQ-025 A full frame SHALL take exactly 4*(DIV+GAP) cycles, with no extra cycles at index wrap.

Reset
REQ-026 While reset=0: state=GAP, counter=0, index=0 (so the first ON slot is index 3), snapshot=all segments 1111111, Minutes snapshot=0, Blank_Lead snapshot=0, An=4'b1111, Seg=7'b1111111, Dp=1, Frame=0.
REQ-027 Reset assertion SHALL take effect immediately (asynchronously) at any point, including mid-slot; after deassertion the first GAP->ON transition SHALL occur GAP cycles later, with a snapshot capture.

Verification
REQ-028 DIV=4, GAP=2; release reset -> Frame pulses at cycle 2; An sequence 0111 x4, 1111 x2, 1011 x4, 1111 x2, 1101 x4, 1111 x2, 1110 x4, repeating with period 24.
REQ-029 Inputs minutes=7'b0000001, tens=7'b1001111, ones=7'b0010010, tenths=7'b0000110 -> Seg equals each value while the matching An bit is low; Dp=0 only while An=1101.
REQ-030 Blank_Lead=1 with Minutes=0 -> Seg=1111111 while An=0111; Minutes=3 -> Seg_Minutes shown.
REQ-031 Change Seg_Tenths_Seconds while index 2 is active -> index 0 of the current frame shows the old value; the next frame shows the new value.
REQ-032 Assert reset mid-ON at index 1 -> outputs go to An=1111, Seg=1111111, Dp=1 without a clock edge; after release the scan restarts at index 3.
REQ-033 Every cycle -> An never has more than one low bit, and An=1111 for at least GAP cycles between any two different digits.

Source files
------------

// File: rtl/seg_scan_mux.sv
// Four-digit multiplexed seven-segment scanner: each digit is lit for DIV cycles,
// separated by GAP dark cycles; the digit inputs are snapshotted once per frame.
module seg_scan_mux #(
    parameter int unsigned DIV = 50000,
    parameter int unsigned GAP = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [0:6] Seg_Minutes,
    input  logic [0:6] Seg_Tens_Seconds,
    input  logic [0:6] Seg_Ones_Seconds,
    input  logic [0:6] Seg_Tenths_Seconds,
    input  logic [3:0] Minutes,
    input  logic       Blank_Lead,
    output logic [0:6] Seg,
    output logic [3:0] An,
    output logic       Dp,
    output logic       Frame
);

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] ON_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
    localparam logic [0:6]    DARK     = 7'b1111111;

    typedef enum logic {ST_GAP, ST_ON} state_t;

    state_t      state;
    logic [CW-1:0] cnt;
    logic [1:0]  idx;
    logic [0:6]  snap_min_seg, snap_tens_seg, snap_ones_seg, snap_tenths_seg;
    logic [3:0]  snap_minutes;
    logic        snap_blank;

    logic [1:0]  nxt_idx;
    logic        capture;
    logic [0:6]  nxt_seg;

    // Segment pattern for the slot about to start. When that slot opens a new frame,
    // the snapshot is being loaded on the same edge, so the live inputs are used.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        nxt_idx = idx - 2'd1;
        capture = (nxt_idx == 2'd3);
        nxt_seg = DARK;
        case (nxt_idx)
            2'd3: begin
                if (capture && !(Blank_Lead && Minutes == 4'd0))
                    nxt_seg = Seg_Minutes;
                else if (!capture && !(snap_blank && snap_minutes == 4'd0))
                    nxt_seg = snap_min_seg;
            end
            2'd2:    nxt_seg = snap_tens_seg;
            2'd1:    nxt_seg = snap_ones_seg;
            default: nxt_seg = snap_tenths_seg;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= ST_GAP;
            cnt             <= '0;
            idx             <= 2'd0;
            snap_min_seg    <= DARK;
            snap_tens_seg   <= DARK;
            snap_ones_seg   <= DARK;
            snap_tenths_seg <= DARK;
            snap_minutes    <= 4'd0;
            snap_blank      <= 1'b0;
            An              <= 4'b1111;
            Seg             <= DARK;
            Dp              <= 1'b1;
            Frame           <= 1'b0;
        end else begin
            Frame <= 1'b0;
            case (state)
                ST_ON: begin
                    if (cnt == ON_LAST) begin
                        state <= ST_GAP;
                        cnt   <= '0;
                        An    <= 4'b1111;
                        Seg   <= DARK;
                        Dp    <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    if (cnt == GAP_LAST) begin
                        state <= ST_ON;
                        cnt   <= '0;
                        idx   <= nxt_idx;
                        An    <= ~(4'b0001 << nxt_idx);
                        Seg   <= nxt_seg;
                        Dp    <= (nxt_idx != 2'd1);
                        if (capture) begin
                            snap_min_seg    <= Seg_Minutes;
                            snap_tens_seg   <= Seg_Tens_Seconds;
                            snap_ones_seg   <= Seg_Ones_Seconds;
                            snap_tenths_seg <= Seg_Tenths_Seconds;
                            snap_minutes    <= Minutes;
                            snap_blank      <= Blank_Lead;
                            Frame           <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux at DIV=4, GAP=2: a timeline model derived from the slot
// arithmetic (frame = 4*(DIV+GAP) cycles) predicts An/Seg/Dp/Frame every cycle.
module tb_seg_scan_mux;

    localparam int DIV  = 4;
    localparam int GAP  = 2;
    localparam int SLOT = DIV + GAP;

    logic       clk = 1'b0;
    logic       reset;
    logic [0:6] seg_minutes, seg_tens, seg_ones, seg_tenths;
    logic [3:0] minutes;
    logic       blank_lead;
    logic [0:6] seg;
    logic [3:0] an;
    logic       dp;
    logic       frame;

    seg_scan_mux #(.DIV(DIV), .GAP(GAP)) dut (
        .clk                (clk),
        .reset              (reset),
        .Seg_Minutes        (seg_minutes),
        .Seg_Tens_Seconds   (seg_tens),
        .Seg_Ones_Seconds   (seg_ones),
        .Seg_Tenths_Seconds (seg_tenths),
        .Minutes            (minutes),
        .Blank_Lead         (blank_lead),
        .Seg                (seg),
        .An                 (an),
        .Dp                 (dp),
        .Frame              (frame)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: edges since reset release and the per-frame input snapshot.
    int         t;
    logic [0:6] snap [4];
    logic [3:0] snap_m;
    logic       snap_b;
    logic       m_on;
    int         m_digit;
    int         m_offset;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < 4; i++) snap[i] = 7'b1111111;
        snap_m = 4'd0;
        snap_b = 1'b0;
    endtask

    // Called at the negedge following t rising edges after release.
    task automatic model_check();
        logic [3:0] e_an;
        logic [0:6] e_seg;
        logic       e_dp, e_fr;
        int u, k;
        e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1; e_fr = 1'b0;
        m_on = 1'b0; m_digit = -1; m_offset = -1;
        if (t >= GAP) begin
            u        = t - GAP;
            k        = u / SLOT;
            m_offset = u % SLOT;
            m_digit  = 3 - (k % 4);
            if (m_offset == 0 && m_digit == 3) begin
                snap[3] = seg_minutes;
                snap[2] = seg_tens;
                snap[1] = seg_ones;
                snap[0] = seg_tenths;
                snap_m  = minutes;
                snap_b  = blank_lead;
                e_fr    = 1'b1;
            end
            if (m_offset < DIV) begin
                m_on  = 1'b1;
                e_an  = 4'b1111;
                e_an[m_digit] = 1'b0;
                e_seg = (m_digit == 3 && snap_b && snap_m == 4'd0) ? 7'b1111111 : snap[m_digit];
                e_dp  = (m_digit != 1);
            end
        end
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
        check("frame", 32'(frame), 32'(e_fr));
        check("an_onehot_low", 32'($countones(~an) <= 1), 32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        t++;
        @(negedge clk);
        model_check();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [0:6] old_tenths;
    logic       found;

    initial begin
        reset       = 1'b0;
        seg_minutes = 7'b0000001;
        seg_tens    = 7'b1001111;
        seg_ones    = 7'b0010010;
        seg_tenths  = 7'b0000110;
        minutes     = 4'd5;
        blank_lead  = 1'b0;
        model_reset();

        // Reset state held across clock edges.
        repeat (3) @(negedge clk);
        check("rst_an", 32'(an), 32'hf);
        check("rst_seg", 32'(seg), 32'h7f);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_frame", 32'(frame), 32'd0);

        // Release: first frame after GAP cycles, then the basic digit patterns.
        reset = 1'b1;
        model_reset();
        model_check();
        run(2 * 4 * SLOT);

        // Leading-zero blanking, then a non-zero minutes value.
        blank_lead = 1'b1;
        minutes    = 4'd0;
        run(2 * 4 * SLOT);
        minutes = 4'd3;
        run(2 * 4 * SLOT);
        blank_lead = 1'b0;

        // Change tenths while digit 2 is lit: this frame must keep the old value.
        found = 1'b0;
        for (int i = 0; i < 4 * SLOT && !found; i++) begin
            tick();
            if (m_on && m_digit == 2) found = 1'b1;
        end
        check("find_digit2", 32'(found), 32'd1);
        old_tenths = seg_tenths;
        seg_tenths = 7'b1111000;
        found = 1'b0;
        for (int i = 0; i < 4 * SLOT && !found; i++) begin
            tick();
            if (m_on && m_digit == 0) found = 1'b1;
        end
        check("find_digit0", 32'(found), 32'd1);
        check("tenths_old_value", 32'(seg), 32'(old_tenths));
        run(4 * SLOT);

        // Randomised inputs, changed on random cycles.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 5))
                    0: seg_minutes = 7'($urandom);
                    1: seg_tens    = 7'($urandom);
                    2: seg_ones    = 7'($urandom);
                    3: seg_tenths  = 7'($urandom);
                    4: minutes     = 4'($urandom_range(0, 3));
                    default: blank_lead = 1'($urandom);
                endcase
            end
            tick();
        end

        // Asynchronous reset in the middle of the digit-1 slot.
        found = 1'b0;
        for (int i = 0; i < 4 * SLOT && !found; i++) begin
            tick();
            if (m_on && m_digit == 1 && m_offset == 1) found = 1'b1;
        end
        check("find_digit1", 32'(found), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_an", 32'(an), 32'hf);
        check("async_seg", 32'(seg), 32'h7f);
        check("async_dp", 32'(dp), 32'd1);
        check("async_frame", 32'(frame), 32'd0);
        repeat (2) @(negedge clk);
        check("hold_an", 32'(an), 32'hf);
        reset = 1'b1;
        model_reset();
        model_check();
        run(2 * 4 * SLOT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
